// File: rtl/lsu_mem_pkg.sv
// Shared types for the LSU memory responder: FSM states, channel encoding
// and the READ_LAT counter width.
package lsu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef enum logic {
        CH_LOAD  = 1'b0,
        CH_STORE = 1'b1
    } channel_t;

    // Wide enough for READ_LAT up to 15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/lsu_mem_responder_if.sv
// LSU load/store channels plus the SRAM port of the responder.
// slave = the responder, master = requester / memory environment.
interface lsu_mem_responder_if #(
    parameter int INDEX_W = 19,
    parameter int DATA_W  = 64
) ();
    logic               opload_index_valid;
    logic [INDEX_W-1:0] opload_index;
    logic               opload_index_ready;
    logic [DATA_W-1:0]  opload_read_data;
    logic               opload_operation_done;

    logic               opstore_index_valid;
    logic [INDEX_W-1:0] opstore_index;
    logic               opstore_index_ready;
    logic [DATA_W-1:0]  opstore_write_data;
    logic [DATA_W-1:0]  opstore_write_mask;
    logic               opstore_operation_done;

    logic               sram_ce;
    logic               sram_we;
    logic [INDEX_W-1:0] sram_addr;
    logic [DATA_W-1:0]  sram_wmask;
    logic [DATA_W-1:0]  sram_wdata;
    logic [DATA_W-1:0]  sram_rdata;

    modport slave (
        input  opload_index_valid, opload_index,
        output opload_index_ready, opload_read_data, opload_operation_done,
        input  opstore_index_valid, opstore_index, opstore_write_data, opstore_write_mask,
        output opstore_index_ready, opstore_operation_done,
        output sram_ce, sram_we, sram_addr, sram_wmask, sram_wdata,
        input  sram_rdata
    );

    modport master (
        output opload_index_valid, opload_index,
        input  opload_index_ready, opload_read_data, opload_operation_done,
        output opstore_index_valid, opstore_index, opstore_write_data, opstore_write_mask,
        input  opstore_index_ready, opstore_operation_done,
        input  sram_ce, sram_we, sram_addr, sram_wmask, sram_wdata,
        output sram_rdata
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. grant[0] = load, grant[1] = store.
// On contention the channel opposite to the last winner is granted.
module rr_arb2
    import lsu_mem_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       req_load,
    input  logic       req_store,
    input  logic       advance,
    output logic [1:0] grant
);
    channel_t last_grant_reg;

    // One-hot grant selection from the current requests and the RR pointer.
    always_comb begin
        grant = 2'b00;
        if (req_load && req_store) begin
            grant = (last_grant_reg == CH_STORE) ? 2'b01 : 2'b10;
        end else if (req_load) begin
            grant = 2'b01;
        end else if (req_store) begin
            grant = 2'b10;
        end
    end

    // RR pointer: starts at STORE so a load wins the first contention.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_reg <= CH_STORE;
        end else if (advance && (grant != 2'b00)) begin
            last_grant_reg <= grant[1] ? CH_STORE : CH_LOAD;
        end
    end
endmodule

// File: rtl/lsu_mem_responder.sv
// Memory-side responder for the LSU load/store channels. Serves one request
// at a time on a single-port synchronous SRAM with fixed read latency.
module lsu_mem_responder
    import lsu_mem_pkg::*;
#(
    parameter int INDEX_W  = 19,
    parameter int DATA_W   = 64,
    parameter int READ_LAT = 1
) (
    input  logic               clock,
    input  logic               reset_n,
    lsu_mem_responder_if.slave bus,
    output logic               busy
);
    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(READ_LAT);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    channel_t           ch_reg;
    logic [DATA_W-1:0]  read_data_reg;
    logic               sram_ce_reg, sram_we_reg;
    logic [INDEX_W-1:0] sram_addr_reg;
    logic [DATA_W-1:0]  sram_wmask_reg, sram_wdata_reg;
    logic               idle, accept;
    logic [1:0]         grant;

    assign idle   = (state_reg == IDLE);
    assign accept = |grant;

    // Requests only reach the arbiter in IDLE, so ready is 0 elsewhere.
    rr_arb2 u_arb (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_load  (idle && bus.opload_index_valid),
        .req_store (idle && bus.opstore_index_valid),
        .advance   (accept),
        .grant     (grant)
    );

    // Next-state and wait-counter logic.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = ACCESS;
            ACCESS: begin
                if (ch_reg == CH_STORE) begin
                    state_next = DONE;
                end else begin
                    state_next = WAIT;
                    cnt_next   = CNT_W'(1);
                end
            end
            WAIT: begin
                if (cnt_reg == LAT_CNT) state_next = DONE;
                else                    cnt_next   = cnt_reg + CNT_W'(1);
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, counter and latched channel registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            ch_reg    <= CH_LOAD;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) ch_reg <= grant[1] ? CH_STORE : CH_LOAD;
        end
    end

    // SRAM strobe and request fields: loaded on acceptance so they are
    // presented during ACCESS only, zero otherwise; loads carry no data/mask.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sram_ce_reg    <= 1'b0;
            sram_we_reg    <= 1'b0;
            sram_addr_reg  <= '0;
            sram_wmask_reg <= '0;
            sram_wdata_reg <= '0;
        end else begin
            sram_ce_reg    <= accept;
            sram_we_reg    <= grant[1];
            sram_addr_reg  <= grant[1] ? bus.opstore_index :
                              (grant[0] ? bus.opload_index : '0);
            sram_wmask_reg <= grant[1] ? bus.opstore_write_mask : '0;
            sram_wdata_reg <= grant[1] ? bus.opstore_write_data : '0;
        end
    end

    // Load result capture on the last WAIT cycle; held until the next load.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            read_data_reg <= '0;
        end else if ((state_reg == WAIT) && (cnt_reg == LAT_CNT) && (ch_reg == CH_LOAD)) begin
            read_data_reg <= bus.sram_rdata;
        end
    end

    assign bus.opload_index_ready     = grant[0];
    assign bus.opstore_index_ready    = grant[1];
    assign bus.opload_read_data       = read_data_reg;
    assign bus.opload_operation_done  = (state_reg == DONE) && (ch_reg == CH_LOAD);
    assign bus.opstore_operation_done = (state_reg == DONE) && (ch_reg == CH_STORE);
    assign bus.sram_ce                = sram_ce_reg;
    assign bus.sram_we                = sram_we_reg;
    assign bus.sram_addr              = sram_addr_reg;
    assign bus.sram_wmask             = sram_wmask_reg;
    assign bus.sram_wdata             = sram_wdata_reg;
    assign busy                       = !idle;
endmodule

// File: tb/tb_lsu_mem_responder.sv
// Directed bench for lsu_mem_responder: a READ_LAT=1 instance for the main
// tests and a READ_LAT=3 instance for the latency test, each with a
// behavioural SRAM that returns junk outside the valid read cycle.
module tb_lsu_mem_responder;
    localparam logic [63:0] JUNK = 64'hBAD0_BAD0_BAD0_BAD0;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic busy1, busy3;
    int   checks = 0;
    int   errors = 0;
    int   ce1_cnt = 0;
    int   done1_cnt = 0;
    logic [63:0] ld_exp1 = '0;

    always #5 clock = ~clock;

    lsu_mem_responder_if #(.INDEX_W(19), .DATA_W(64)) b1 ();
    lsu_mem_responder_if #(.INDEX_W(19), .DATA_W(64)) b3 ();

    lsu_mem_responder #(.INDEX_W(19), .DATA_W(64), .READ_LAT(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .bus(b1), .busy(busy1));
    lsu_mem_responder #(.INDEX_W(19), .DATA_W(64), .READ_LAT(3)) dut3 (
        .clock(clock), .reset_n(reset_n), .bus(b3), .busy(busy3));

    // Behavioural SRAMs
    logic [63:0] mem1 [logic [18:0]];
    logic [63:0] mem3 [logic [18:0]];
    logic [63:0] pipe3 [3];
    logic [63:0] old1;

    always @(posedge clock) begin
        if (b1.sram_ce && b1.sram_we) begin
            old1 = mem1.exists(b1.sram_addr) ? mem1[b1.sram_addr] : 64'd0;
            mem1[b1.sram_addr] = (old1 & ~b1.sram_wmask) | (b1.sram_wdata & b1.sram_wmask);
        end
        b1.sram_rdata <= (b1.sram_ce && !b1.sram_we && mem1.exists(b1.sram_addr)) ?
                         mem1[b1.sram_addr] : JUNK;
        pipe3[0] <= (b3.sram_ce && !b3.sram_we && mem3.exists(b3.sram_addr)) ?
                    mem3[b3.sram_addr] : JUNK;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign b3.sram_rdata = pipe3[2];

    // Pulse counters for the duplicate-acceptance test
    always @(negedge clock) begin
        if (b1.sram_ce) ce1_cnt++;
        if (b1.opload_operation_done || b1.opstore_operation_done) done1_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    // Store on the READ_LAT=1 instance; valid held through done, dropped after.
    task automatic run_store(input logic [18:0] idx, input logic [63:0] data, input logic [63:0] mask);
        b1.opstore_index_valid = 1'b1;
        b1.opstore_index       = idx;
        b1.opstore_write_data  = data;
        b1.opstore_write_mask  = mask;
        mid();
        check("st_ready_A", 64'(b1.opstore_index_ready), 64'(1));
        check("st_busy_A", 64'(busy1), 64'(0));
        step(); mid();
        check("st_ce", 64'(b1.sram_ce), 64'(1));
        check("st_we", 64'(b1.sram_we), 64'(1));
        check("st_addr", 64'(b1.sram_addr), 64'(idx));
        check("st_wdata", b1.sram_wdata, data);
        check("st_wmask", b1.sram_wmask, mask);
        check("st_busy", 64'(busy1), 64'(1));
        check("st_ready_busy", 64'(b1.opstore_index_ready), 64'(0));
        step(); mid();
        check("st_done", 64'(b1.opstore_operation_done), 64'(1));
        check("st_ld_done_quiet", 64'(b1.opload_operation_done), 64'(0));
        check("st_ready_in_done", 64'(b1.opstore_index_ready), 64'(0));
        check("st_ce_off", 64'(b1.sram_ce), 64'(0));
        step();
        b1.opstore_index_valid = 1'b0;
        mid();
        check("st_done_off", 64'(b1.opstore_operation_done), 64'(0));
        check("st_idle", 64'(busy1), 64'(0));
        check("st_rdata_kept", b1.opload_read_data, ld_exp1);
        $display("store idx=%h data=%h mask=%h", idx, data, mask);
        step();
    endtask

    // Load on the READ_LAT=1 instance: capture at A+2, done at A+3.
    task automatic run_load(input logic [18:0] idx, input logic [63:0] exp);
        b1.opload_index_valid = 1'b1;
        b1.opload_index       = idx;
        mid();
        check("ld_ready_A", 64'(b1.opload_index_ready), 64'(1));
        check("ld_st_ready_A", 64'(b1.opstore_index_ready), 64'(0));
        step(); mid();
        check("ld_ce", 64'(b1.sram_ce), 64'(1));
        check("ld_we", 64'(b1.sram_we), 64'(0));
        check("ld_addr", 64'(b1.sram_addr), 64'(idx));
        check("ld_wmask", b1.sram_wmask, 64'd0);
        check("ld_wdata", b1.sram_wdata, 64'd0);
        step(); mid();
        check("ld_done_early", 64'(b1.opload_operation_done), 64'(0));
        check("ld_rdata_old", b1.opload_read_data, ld_exp1);
        step(); mid();
        check("ld_done", 64'(b1.opload_operation_done), 64'(1));
        check("ld_ready_in_done", 64'(b1.opload_index_ready), 64'(0));
        check("ld_rdata", b1.opload_read_data, exp);
        ld_exp1 = exp;
        step();
        b1.opload_index_valid = 1'b0;
        mid();
        check("ld_done_off", 64'(b1.opload_operation_done), 64'(0));
        check("ld_idle", 64'(busy1), 64'(0));
        $display("load idx=%h data=%h", idx, b1.opload_read_data);
        step();
    endtask

    initial begin
        int c0, d0;
        int gch[$];
        int gcy[$];

        b1.opload_index_valid = 1'b0; b1.opload_index = '0;
        b1.opstore_index_valid = 1'b0; b1.opstore_index = '0;
        b1.opstore_write_data = '0; b1.opstore_write_mask = '0;
        b3.opload_index_valid = 1'b0; b3.opload_index = '0;
        b3.opstore_index_valid = 1'b0; b3.opstore_index = '0;
        b3.opstore_write_data = '0; b3.opstore_write_mask = '0;
        mem1[19'h00020] = 64'h11111111_22222222;
        mem3[19'h7FFFF] = 64'h01234567_89ABCDEF;

        // Reset state
        mid();
        check("rst_busy1", 64'(busy1), 64'(0));
        check("rst_busy3", 64'(busy3), 64'(0));
        check("rst_ld_ready", 64'(b1.opload_index_ready), 64'(0));
        check("rst_st_ready", 64'(b1.opstore_index_ready), 64'(0));
        check("rst_ce", 64'(b1.sram_ce), 64'(0));
        check("rst_addr", 64'(b1.sram_addr), 64'(0));
        check("rst_rdata", b1.opload_read_data, 64'd0);
        check("rst_done", 64'(b1.opload_operation_done | b1.opstore_operation_done), 64'(0));
        $display("reset checked");
        step();
        reset_n = 1'b1;
        step();

        // Full store, then partial store followed by a load of the same word
        run_store(19'h00010, 64'hDEADBEEF_CAFEF00D, 64'hFFFFFFFF_FFFFFFFF);
        run_store(19'h00020, 64'hFFFFFFFF_DEADBEEF, 64'h00000000_FFFFFFFF);
        run_load(19'h00020, 64'h11111111_DEADBEEF);

        // READ_LAT=3 load of the top index
        b3.opload_index_valid = 1'b1;
        b3.opload_index = 19'h7FFFF;
        mid();
        check("l3_ready", 64'(b3.opload_index_ready), 64'(1));
        step(); mid();
        check("l3_ce", 64'(b3.sram_ce), 64'(1));
        check("l3_addr", 64'(b3.sram_addr), 64'h7FFFF);
        for (int k = 2; k <= 4; k++) begin
            step(); mid();
            check("l3_done_early", 64'(b3.opload_operation_done), 64'(0));
            check("l3_rdata_old", b3.opload_read_data, 64'd0);
            check("l3_busy", 64'(busy3), 64'(1));
        end
        step(); mid();
        check("l3_done", 64'(b3.opload_operation_done), 64'(1));
        check("l3_rdata", b3.opload_read_data, 64'h01234567_89ABCDEF);
        step();
        b3.opload_index_valid = 1'b0;
        mid();
        check("l3_done_off", 64'(b3.opload_operation_done), 64'(0));
        check("l3_idle", 64'(busy3), 64'(0));
        $display("load3 idx=7ffff data=%h", b3.opload_read_data);
        step();

        // One sram_ce and one done per request while valid is held through done
        c0 = ce1_cnt;
        d0 = done1_cnt;
        run_store(19'h00050, 64'h55555555_AAAAAAAA, 64'hFFFFFFFF_FFFFFFFF);
        run_load(19'h00050, 64'h55555555_AAAAAAAA);
        check("ce_pulses", 64'(ce1_cnt - c0), 64'(2));
        check("done_pulses", 64'(done1_cnt - d0), 64'(2));

        // Reset during WAIT of a load
        b1.opload_index_valid = 1'b1;
        b1.opload_index = 19'h00020;
        step(); step();
        reset_n = 1'b0;
        b1.opload_index_valid = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy1), 64'(0));
        check("mid_rst_rdata", b1.opload_read_data, 64'd0);
        check("mid_rst_ce", 64'(b1.sram_ce), 64'(0));
        d0 = done1_cnt;
        step(); step();
        reset_n = 1'b1;
        step(); step();
        check("mid_rst_no_done", 64'(done1_cnt - d0), 64'(0));
        ld_exp1 = '0;
        $display("reset during load wait");
        run_store(19'h00030, 64'h0F0F0F0F_0F0F0F0F, 64'hFFFF0000_FFFF0000);
        check("post_rst_rdata", b1.opload_read_data, 64'd0);

        // Contention from reset with both requesters held: L,S,L,S
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        b1.opload_index_valid = 1'b1;
        b1.opload_index = 19'h00020;
        b1.opstore_index_valid = 1'b1;
        b1.opstore_index = 19'h00040;
        b1.opstore_write_data = 64'h12345678_9ABCDEF0;
        b1.opstore_write_mask = 64'hFFFFFFFF_FFFFFFFF;
        for (int cyc = 0; cyc < 14; cyc++) begin
            mid();
            check("one_ready", 64'(b1.opload_index_ready & b1.opstore_index_ready), 64'(0));
            if (b1.opload_index_ready) begin gch.push_back(0); gcy.push_back(cyc); end
            if (b1.opstore_index_ready) begin gch.push_back(1); gcy.push_back(cyc); end
            step();
        end
        b1.opload_index_valid = 1'b0;
        b1.opstore_index_valid = 1'b0;
        check("rr_count", 64'(gch.size()), 64'(4));
        for (int i = 0; i < gch.size() && i < 4; i++) begin
            check("rr_channel", 64'(gch[i]), 64'(i % 2));
            check("rr_cycle", 64'(gcy[i]), (i == 0) ? 64'd0 : (i == 1) ? 64'd4 : (i == 2) ? 64'd7 : 64'd11);
            $display("grant %0d: %s at cycle %0d", i, (gch[i] == 0) ? "load" : "store", gcy[i]);
        end
        repeat (6) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
